// File: rtl/uart_tx_serializer.sv
// Buffered 8N1 UART transmitter: bytes queue in a small circular FIFO.
// The FSM shifts them out LSB-first on a registered txd line.
module uart_tx_serializer #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       busy,
    output logic       txd
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    typedef logic [7:0] byte_t;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_next;
    byte_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       idx, idx_nxt;
    byte_t            shift;
    logic             bit_done, not_empty, push, pop, txd_d;

    assign not_empty = count != '0;
    assign full      = count == CW'(FIFO_DEPTH);
    assign busy      = not_empty | (state != IDLE);
    assign push      = wr_en & ~full;
    assign bit_done  = baud_cnt == CNT_W'(DIV - 1);
    assign idx_nxt   = idx + 3'd1;

    // A push while full is dropped even when a pop frees a slot on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (not_empty) state_next = START;
            START: if (bit_done) state_next = DATA;
            DATA:  if (bit_done && idx == 3'd7) state_next = STOP;
            STOP:  if (bit_done) state_next = not_empty ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop   = 1'b0;
        txd_d = 1'b1;
        case (state)
            IDLE: begin
                pop   = not_empty;
                txd_d = ~not_empty;
            end
            START: txd_d = bit_done ? shift[0] : 1'b0;
            DATA: begin
                if (!bit_done)        txd_d = shift[idx];
                else if (idx == 3'd7) txd_d = 1'b1;
                else                  txd_d = shift[idx_nxt];
            end
            STOP: begin
                pop   = bit_done & not_empty;
                txd_d = ~(bit_done & not_empty);
            end
            default: ;
        endcase
    end

    // Baud counter idles at 0 so every state entry starts a fresh bit period
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            idx      <= '0;
            shift    <= '0;
            txd      <= 1'b1;
        end else begin
            txd <= txd_d;
            if (state == IDLE || bit_done) baud_cnt <= '0;
            else                           baud_cnt <= baud_cnt + CNT_W'(1);
            if (state == START && bit_done)     idx <= '0;
            else if (state == DATA && bit_done) idx <= idx_nxt;
            if (pop) shift <= mem[rd_ptr];
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: queue-level line model compared every cycle,
// plus literal expectations at hand-picked edges for each directed scenario.
module tb_uart_tx_serializer;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, busy, txd;

    uart_tx_serializer #(.CLK_FREQ(400), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .busy(busy), .txd(txd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: byte queue plus the line waveform still owed, one entry per clock
    logic [7:0] q[$];
    logic       line[$];
    bit         in_frame = 1'b0;
    logic       exp_txd = 1'b1;
    int         frames = 0;
    bit         mvalid = 1'b0;

    function automatic void start_frame(logic [7:0] b);
        for (int k = 0; k < DIV; k++) line.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < DIV; k++) line.push_back(b[i]);
        for (int k = 0; k < DIV; k++) line.push_back(1'b1);
    endfunction

    always @(posedge clk) begin
        bit was_full;
        if (rst) begin
            q.delete();
            line.delete();
            in_frame = 1'b0;
            exp_txd  = 1'b1;
            mvalid   = 1'b1;
        end else if (mvalid) begin
            was_full = (q.size() == DEPTH);
            if (line.size() == 0) begin
                if (q.size() != 0) begin
                    start_frame(q.pop_front());
                    frames++;
                    exp_txd  = line.pop_front();
                    in_frame = 1'b1;
                end else begin
                    in_frame = 1'b0;
                    exp_txd  = 1'b1;
                end
            end else begin
                exp_txd  = line.pop_front();
                in_frame = 1'b1;
            end
            if (wr_en && !was_full) q.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_txd", txd, exp_txd);
            chk("model_busy", busy, (q.size() != 0) || in_frame);
            chk("model_full", full, q.size() == DEPTH);
        end
    end

    task automatic ticks(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push1(logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        ticks(1);
        wr_en = 1'b0;
    endtask

    initial begin
        int f0;
        // 1. reset and hold idle
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
        ticks(20);
        chk("idle_txd", txd, 1'b1);

        // 2. single frame 0xA5; comments give the edge just sampled after
        f0 = frames;
        push1(8'hA5);                          // edge 0
        chk("a5_busy_e0", busy, 1'b1);
        chk("a5_txd_e0", txd, 1'b1);
        ticks(1);  chk("a5_start_e1", txd, 1'b0);
        ticks(4);  chk("a5_b0_e5", txd, 1'b1);
        ticks(4);  chk("a5_b1_e9", txd, 1'b0);
        ticks(20); chk("a5_b6_e29", txd, 1'b0);
        ticks(4);  chk("a5_b7_e33", txd, 1'b1);
        ticks(4);  chk("a5_stop_e37", txd, 1'b1);
        ticks(3);  chk("a5_busy_e40", busy, 1'b1);
        ticks(1);  chk("a5_busy_e41", busy, 1'b0);
        chk_int("a5_frames", frames - f0, 1);
        ticks(5);

        // 3. three back-to-back frames
        f0 = frames;
        wr_en = 1'b1;
        wr_data = 8'h01; ticks(1);
        wr_data = 8'h02; ticks(1);
        wr_data = 8'h03; ticks(1);
        wr_en = 1'b0;                          // after edge 2
        ticks(38); chk("b2b_stop_e40", txd, 1'b1);
        ticks(1);  chk("b2b_start_e41", txd, 1'b0);
        ticks(79); chk("b2b_busy_e120", busy, 1'b1);
        ticks(1);  chk("b2b_busy_e121", busy, 1'b0);
        chk_int("b2b_frames", frames - f0, 3);
        ticks(5);

        // 4. six pushes, the sixth meets a full FIFO
        f0 = frames;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h10 + 8'(i);
            ticks(1);
            if (i == 3) chk("ovf_full_e3", full, 1'b0);
            if (i == 4) chk("ovf_full_e4", full, 1'b1);
        end
        wr_en = 1'b0;
        chk("ovf_full_e5", full, 1'b1);
        ticks(250);
        chk_int("ovf_frames", frames - f0, 5);
        chk("ovf_busy_end", busy, 1'b0);
        ticks(5);

        // 5. push and pop on the same edge while full
        f0 = frames;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h20 + 8'(i);
            ticks(1);
        end
        wr_en = 1'b0;                          // after edge 4
        chk("pp_full_e4", full, 1'b1);
        ticks(36); chk("pp_full_e40", full, 1'b1);
        push1(8'hEE);                          // edge 41: pop + dropped push
        chk("pp_full_e41", full, 1'b0);
        ticks(250);
        chk_int("pp_frames", frames - f0, 5);
        chk("pp_busy_end", busy, 1'b0);
        ticks(5);

        // 6. reset in the middle of DATA of 0x5A, then a clean frame
        push1(8'h5A);                          // edge 0
        ticks(14);                             // after edge 14: bit 2
        chk("abort_b2_e14", txd, 1'b0);
        rst = 1'b1;
        ticks(1);
        rst = 1'b0;
        chk("abort_txd", txd, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_full", full, 1'b0);
        f0 = frames;
        push1(8'h3C);
        ticks(1);  chk("clean_start", txd, 1'b0);
        ticks(12); chk("clean_b2", txd, 1'b1);
        ticks(32);
        chk_int("clean_frames", frames - f0, 1);
        chk("clean_busy_end", busy, 1'b0);
        chk("clean_txd_end", txd, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
